spi_master_byte: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0), MSB-first, 8-bit full-duplex transfers.
- It is the initiating end for the team's SPI slave. It generates SCLK, MOSI and CS_n, and samples MISO.
- The system side hands it one byte per transfer through a valid/ready handshake. It returns the received byte with a one-cycle valid pulse.
- It sits in the FPGA system-clock domain and drives the SPI pins directly.

---
 rtl/spi_master_byte.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_byte.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte master, MSB first, full duplex, valid/ready system side.
// Define SPI_MASTER_AUTO_CS_EN for automatic CS_n framing (setup, hold, inter-transfer gap).
module spi_master_byte #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_IDLE_CLKS      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_cs_n
);

    localparam int                HALF_W    = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);

    generate
        if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half
            $error("CLKS_PER_HALF_BIT must be at least 2");
        end
        if (CS_IDLE_CLKS < 1) begin : g_bad_gap
            $error("CS_IDLE_CLKS must be at least 1");
        end
    endgenerate

`ifdef SPI_MASTER_AUTO_CS_EN
    localparam int               GAP_W    = (CS_IDLE_CLKS > 1) ? $clog2(CS_IDLE_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, CS_GAP} state_e;

    logic [GAP_W-1:0] gap_q, gap_d;
    logic             cs_n_q, cs_n_d;
`else
    typedef enum logic {IDLE, XFER} state_e;
`endif

    state_e            state_q, state_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [4:0]        bit_q, bit_d;     // SCLK toggles completed, 0..16
    logic              sclk_q, sclk_d;
    logic [7:0]        tx_q, tx_d;       // MOSI is always tx_q[7]
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_dv_q, rx_dv_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            half_q    <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
`ifdef SPI_MASTER_AUTO_CS_EN
            gap_q     <= '0;
            cs_n_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
`ifdef SPI_MASTER_AUTO_CS_EN
            gap_q     <= gap_d;
            cs_n_q    <= cs_n_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path can infer a latch.
        state_d   = state_q;
        half_d    = half_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
`ifdef SPI_MASTER_AUTO_CS_EN
        gap_d     = gap_q;
        cs_n_d    = cs_n_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_tx_dv) begin
                    tx_d    = i_tx_byte;
                    half_d  = '0;
                    bit_d   = '0;
                    rx_sh_d = '0;
`ifdef SPI_MASTER_AUTO_CS_EN
                    cs_n_d  = 1'b0;
                    state_d = CS_SETUP;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef SPI_MASTER_AUTO_CS_EN
            CS_SETUP: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = XFER;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
`endif
            XFER: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    sclk_d = ~sclk_q;
                    bit_d  = bit_q + 5'd1;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[6:0], i_spi_miso};
                    end else if (bit_q == 5'd15) begin
                        // Final falling edge: MOSI keeps bit 0, no further shift.
`ifdef SPI_MASTER_AUTO_CS_EN
                        state_d = CS_HOLD;
`else
                        state_d   = IDLE;
                        rx_dv_d   = 1'b1;
                        rx_byte_d = rx_sh_q;
`endif
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
`ifdef SPI_MASTER_AUTO_CS_EN
            CS_HOLD: begin
                if (half_q == HALF_LAST) begin
                    half_d    = '0;
                    gap_d     = '0;
                    cs_n_d    = 1'b1;
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_sh_q;
                    state_d   = CS_GAP;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            CS_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign o_tx_ready = (state_q == IDLE);
    assign o_rx_dv    = rx_dv_q;
    assign o_rx_byte  = rx_byte_q;
    assign o_spi_clk  = sclk_q;
    assign o_spi_mosi = tx_q[7];
`ifdef SPI_MASTER_AUTO_CS_EN
    assign o_spi_cs_n = cs_n_q;
`else
    assign o_spi_cs_n = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_byte.sv
// Self-checking bench for spi_master_byte: cycle-accurate expectations derived from the
// SCLK toggle schedule, a slave that presents MISO only in the cycle before each rise.
module tb_spi_master_byte;

    localparam int N       = 2;
    localparam int CS_IDLE = 4;
`ifdef SPI_MASTER_AUTO_CS_EN
    localparam int   XS          = 1 + N;           // cycle XFER begins
    localparam int   DONE_LAT    = 1 + 18 * N;      // rx_dv / CS_n rise
    localparam int   READY_LAT   = DONE_LAT + CS_IDLE;
    localparam int   B2B_GAP     = READY_LAT;
    localparam logic CS_IDLE_VAL = 1'b1;
`else
    localparam int   XS          = 1;
    localparam int   DONE_LAT    = 1 + 16 * N;
    localparam int   READY_LAT   = 1 + 16 * N;
    localparam int   B2B_GAP     = 16 * N + 1;
    localparam logic CS_IDLE_VAL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;
    logic       loop_mode;
    logic       miso_drv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign miso = loop_mode ? mosi : miso_drv;

    spi_master_byte #(.CLKS_PER_HALF_BIT(N), .CS_IDLE_CLKS(CS_IDLE)) dut (
        .i_clk(clk), .i_rst(rst), .i_tx_dv(tx_dv), .i_tx_byte(tx_byte),
        .o_tx_ready(tx_ready), .o_rx_dv(rx_dv), .o_rx_byte(rx_byte),
        .o_spi_clk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso), .o_spi_cs_n(cs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Number of SCLK toggles that have happened by cycle c (accept = cycle 0).
    function automatic int toggles(input int c);
        int t;
        if (c < XS + N) return 0;
        t = (c - XS) / N;
        return (t > 16) ? 16 : t;
    endfunction

    // One transfer checked cycle by cycle. rst_c>0 aborts it with reset at that cycle;
    // inject_c>0 pulses a spurious request; chain requests the next byte as ready returns.
    task automatic run_xfer(input string name, input logic [7:0] tx, input logic [7:0] sl,
                            input bit loop, input bit skip_accept, input int inject_c,
                            input int rst_c, input bit chain, input logic [7:0] chain_byte,
                            output int rx_time);
        logic [7:0] exp_rx;
        int         last_c, pulses, tg, tgn, k, w;
        bit         aborted;
        logic       e_sclk, e_mosi, e_ready, e_dv, e_cs;
        exp_rx    = loop ? tx : sl;
        last_c    = (rst_c > 0) ? DONE_LAT + 2 : READY_LAT;
        pulses    = 0;
        rx_time   = -1;
        loop_mode = loop;
        if (!skip_accept) begin
            w = 0;
            @(negedge clk);
            while (!tx_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            total++;
            if (tx_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s accept_wait: tx_ready=%b required=1", name, tx_ready);
                return;
            end
            tx_dv    = 1'b1;
            tx_byte  = tx;
            miso_drv = 1'($urandom);
        end
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            aborted = (rst_c > 0) && (c > rst_c);
            tg      = toggles(c);
            if (aborted) begin
                e_sclk = 1'b0; e_mosi = 1'b0; e_ready = 1'b1; e_dv = 1'b0; e_cs = CS_IDLE_VAL;
            end else begin
                k       = (tg / 2 > 7) ? 7 : tg / 2;
                e_sclk  = tg[0];
                e_mosi  = tx[7 - k];
                e_ready = (c >= READY_LAT);
                e_dv    = (c == DONE_LAT);
                e_cs    = CS_IDLE_VAL ? (c >= DONE_LAT) : 1'b0;
            end
            total += 5;
            if (sclk !== e_sclk) begin
                bad++; $display("FAIL %s sclk c=%0d: got %b required %b", name, c, sclk, e_sclk);
            end
            if (mosi !== e_mosi) begin
                bad++; $display("FAIL %s mosi c=%0d: got %b required %b", name, c, mosi, e_mosi);
            end
            if (tx_ready !== e_ready) begin
                bad++; $display("FAIL %s tx_ready c=%0d: got %b required %b", name, c, tx_ready, e_ready);
            end
            if (rx_dv !== e_dv) begin
                bad++; $display("FAIL %s rx_dv c=%0d: got %b required %b", name, c, rx_dv, e_dv);
            end
            if (cs_n !== e_cs) begin
                bad++; $display("FAIL %s cs_n c=%0d: got %b required %b", name, c, cs_n, e_cs);
            end
            if (!aborted && c == DONE_LAT) begin
                total++;
                if (rx_byte !== exp_rx) begin
                    bad++; $display("FAIL %s rx_byte: got %h required %h", name, rx_byte, exp_rx);
                end
            end
            if (aborted && c == last_c) begin
                total++;
                if (rx_byte !== 8'h00) begin
                    bad++; $display("FAIL %s rx_byte_after_abort: got %h required 00", name, rx_byte);
                end
            end
            if (rx_dv === 1'b1) begin
                pulses++;
                rx_time = cyc;
            end
            rst     = (c == rst_c);
            tx_dv   = 1'b0;
            tx_byte = 8'($urandom);
            if (c == inject_c) begin
                tx_dv = 1'b1; tx_byte = 8'h3C;
            end
            if (chain && c == last_c) begin
                tx_dv = 1'b1; tx_byte = chain_byte;
            end
            tgn      = toggles(c + 1);
            miso_drv = (!aborted && c != rst_c && tgn != tg && tgn[0]) ? sl[7 - tgn / 2]
                                                                       : 1'($urandom);
        end
        total++;
        if (pulses != ((rst_c > 0) ? 0 : 1)) begin
            bad++; $display("FAIL %s rx_dv_pulses: got %0d required %0d", name, pulses,
                            (rst_c > 0) ? 0 : 1);
        end
    endtask

    task automatic test_quiet(input string name, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            total++;
            if (sclk !== 1'b0 || tx_ready !== 1'b1 || rx_dv !== 1'b0) begin
                bad++;
                $display("FAIL %s quiet i=%0d: sclk=%b ready=%b rx_dv=%b required 0/1/0",
                         name, i, sclk, tx_ready, rx_dv);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_dv = 1'b0; tx_byte = 8'h00; loop_mode = 1'b0; miso_drv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_ready, rx_dv, rx_byte, sclk, mosi, cs_n} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, CS_IDLE_VAL}) begin
            bad++;
            $display("FAIL reset_values: ready=%b rx_dv=%b rx_byte=%h sclk=%b mosi=%b cs_n=%b required 1 0 00 0 0 %b",
                     tx_ready, rx_dv, rx_byte, sclk, mosi, cs_n, CS_IDLE_VAL);
        end
    endtask

    task automatic test_loopback();
        int t;
        run_xfer("loopback_a5", 8'hA5, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 8'h00, t);
    endtask

    task automatic test_slave_55();
        int t;
        run_xfer("slave_55", 8'hFF, 8'h55, 1'b0, 1'b0, 0, 0, 1'b0, 8'h00, t);
    endtask

    task automatic test_random();
        int t;
        for (int i = 0; i < 6; i++)
            run_xfer("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0, 0, 1'b0, 8'h00, t);
    endtask

    task automatic test_ignore_busy();
        int t;
        run_xfer("ignore_busy", 8'hA5, 8'hC6, 1'b0, 1'b0, 10, 0, 1'b0, 8'h00, t);
        test_quiet("ignore_busy", 2 * N + 4);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        run_xfer("b2b_first", 8'hA5, 8'h3A, 1'b0, 1'b0, 0, 0, 1'b1, 8'h0F, t1);
        run_xfer("b2b_second", 8'h0F, 8'hE1, 1'b0, 1'b1, 0, 0, 1'b0, 8'h00, t2);
        total++;
        if (t2 - t1 != B2B_GAP) begin
            bad++; $display("FAIL b2b_gap: got %0d required %0d", t2 - t1, B2B_GAP);
        end
    endtask

    task automatic test_mid_reset();
        int t;
        run_xfer("mid_reset", 8'hA5, 8'h77, 1'b0, 1'b0, 0, 12, 1'b0, 8'h00, t);
        run_xfer("after_reset_81", 8'h81, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0, 8'h00, t);
    endtask

    task automatic test_reset_with_dv();
        @(negedge clk);
        rst = 1'b1; tx_dv = 1'b1; tx_byte = 8'hC3;
        @(negedge clk);
        rst = 1'b0; tx_dv = 1'b0;
        total++;
        if ({tx_ready, sclk, mosi, rx_dv, cs_n} !== {1'b1, 1'b0, 1'b0, 1'b0, CS_IDLE_VAL}) begin
            bad++;
            $display("FAIL reset_with_dv: ready=%b sclk=%b mosi=%b rx_dv=%b cs_n=%b required 1 0 0 0 %b",
                     tx_ready, sclk, mosi, rx_dv, cs_n, CS_IDLE_VAL);
        end
        test_quiet("reset_with_dv", 2 * N + 2);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave_55();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        test_reset_with_dv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
